proc_chain_readout: RTL

Readout sequencer at the tail of one processor column in the GF systolic array. On `start` it drives the column's op/gauss_op bus with the shift-out opcode, so every processor's `r` register moves one position down the `dataB` chain per cycle. It captures the values leaving the last processor, packs them into `WORD_W`-bit words, and delivers the words through a small output FIFO with valid/ready handshake. It is the reader for the result registers that the processor elements write during Gaussian elimination and evaluation.

---
 rtl/proc_chain_readout.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/proc_chain_readout.sv
// Readout sequencer for the tail of one GF processor column.
// Shifts every processor's r register down the dataB chain, packs the elements leaving
// the last processor into WORD_W-bit words and hands them out through a small FIFO.
// Optional feature: define READOUT_ROTATE_EN to feed the tail back into the head so the
// column contents survive a readout (requires OP_LAT == 0).
module proc_chain_readout #(
   parameter int unsigned GF_BIT      = 4,
   parameter int unsigned OP_CODE_LEN = 4,
   parameter int unsigned CHAIN_LEN   = 8,
   parameter int unsigned WORD_W      = 32,
   parameter int unsigned OP_LAT      = 0,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_start,
   output logic                   o_busy,
   output logic                   o_done,
   output logic [OP_CODE_LEN-1:0] o_op_out,
   output logic [1:0]             o_gauss_op_out,
   output logic                   o_start_out,
   output logic [GF_BIT-1:0]      o_dataB_head,
   input  logic [GF_BIT-1:0]      i_dataB_tail,
   output logic [WORD_W-1:0]      o_out_data,
   output logic                   o_out_last,
   output logic                   o_out_valid,
   input  logic                   i_out_ready
);

   localparam int unsigned EPW        = WORD_W / GF_BIT;
   localparam int unsigned CNT_W      = $clog2(CHAIN_LEN + 1);
   localparam int unsigned PACK_W     = $clog2(EPW + 1);
   localparam int unsigned FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);

   localparam logic [OP_CODE_LEN-1:0] SHIFT_OP = OP_CODE_LEN'(4'b0101);
   localparam logic [OP_CODE_LEN-1:0] HOLD_OP  = '0;

   // Parameter sanity checks at elaboration
   if (WORD_W % GF_BIT != 0) begin : g_chk_word
      $error("WORD_W must be a multiple of GF_BIT");
   end
   if (OP_LAT >= EPW) begin : g_chk_lat
      $error("OP_LAT must be below WORD_W/GF_BIT");
   end
   if (FIFO_DEPTH < 2) begin : g_chk_depth
      $error("FIFO_DEPTH must be at least 2");
   end
   if (CHAIN_LEN < 1) begin : g_chk_chain
      $error("CHAIN_LEN must be at least 1");
   end
`ifdef READOUT_ROTATE_EN
   if (OP_LAT != 0) begin : g_chk_rotate
      $error("READOUT_ROTATE_EN requires OP_LAT == 0");
   end
`endif

   typedef enum logic [1:0] {StIdle, StShift, StDrain, StDone} state_t;

   state_t                   r_state;
   logic [OP_CODE_LEN-1:0]   r_op;
   logic                     r_busy;
   logic                     r_done;
   logic [CNT_W-1:0]         r_issued;
   logic [CNT_W-1:0]         r_inflight;
   logic [CNT_W-1:0]         r_captured;
   logic [PACK_W-1:0]        r_pack_cnt;
   logic [WORD_W-1:0]        r_pack;

   logic [WORD_W:0]          r_fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]         r_wptr;
   logic [PTR_W-1:0]         r_rptr;
   logic [FIFO_CNT_W-1:0]    r_fifo_cnt;

   logic                     w_is_shift;
   logic                     w_cap;
   logic                     w_credit;
   logic                     w_issue;
   logic                     w_clear;
   logic                     w_push;
   logic                     w_push_last;
   logic                     w_pop;
   int                       w_space;
   logic [WORD_W-1:0]        w_pack_nxt;
   logic [PACK_W-1:0]        w_pack_cnt_nxt;
   logic [CNT_W-1:0]         w_captured_nxt;
   logic [PTR_W-1:0]         w_wptr_nxt;
   logic [PTR_W-1:0]         w_rptr_nxt;

   assign w_is_shift = (r_op == SHIFT_OP);

   // Capture tag: the shift issued OP_LAT cycles ago has its element on the tail now
   if (OP_LAT == 0) begin : g_tag_direct
      assign w_cap = w_is_shift;
   end else begin : g_tag_pipe
      logic [OP_LAT-1:0] r_tag;

      // Delay line of issued-shift tags
      always_ff @(posedge i_clk) begin
         if (i_rst) begin
            r_tag <= '0;
         end else begin
            r_tag[0] <= w_is_shift;
            for (int i = 1; i < int'(OP_LAT); i++) begin
               r_tag[i] <= r_tag[i-1];
            end
         end
      end

      assign w_cap = r_tag[OP_LAT-1];
   end

   // Credit: free FIFO element slots minus what is already packed or still in flight.
   // Uses the registered FIFO count, so a pop is only credited one cycle later.
   always_comb begin
      w_space  = (int'(FIFO_DEPTH) - int'(r_fifo_cnt)) * int'(EPW)
                 - int'(r_pack_cnt) - int'(r_inflight);
      w_credit = (w_space >= 1);
      w_issue  = w_credit && (((r_state == StIdle) && i_start) ||
                              ((r_state == StShift) && (r_issued < CNT_W'(CHAIN_LEN))));
   end

   assign w_clear     = (r_state == StIdle) && i_start;
   assign w_push_last = (r_captured == CNT_W'(CHAIN_LEN));
   assign w_push      = ((r_state == StShift) || (r_state == StDrain)) &&
                        ((r_pack_cnt == PACK_W'(EPW)) ||
                         (w_push_last && (r_pack_cnt != '0)));
   assign w_pop       = (r_fifo_cnt != '0) && i_out_ready;

   // Sequencer FSM with registered op, busy and done outputs
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= StIdle;
         r_op       <= HOLD_OP;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_issued   <= '0;
         r_inflight <= '0;
      end else begin
         r_done     <= 1'b0;
         r_op       <= w_issue ? SHIFT_OP : HOLD_OP;
         r_inflight <= r_inflight + CNT_W'(w_issue) - CNT_W'(w_cap);
         case (r_state)
            StIdle: begin
               if (i_start) begin
                  r_busy   <= 1'b1;
                  r_issued <= CNT_W'(w_issue);
                  if (w_issue && (CHAIN_LEN == 1)) begin
                     r_state <= StDrain;
                  end else begin
                     r_state <= StShift;
                  end
               end
            end
            StShift: begin
               if (w_issue) begin
                  r_issued <= r_issued + 1'b1;
                  if ((r_issued + 1'b1) == CNT_W'(CHAIN_LEN)) begin
                     r_state <= StDrain;
                  end
               end
            end
            StDrain: begin
               if (w_push && w_push_last) begin
                  r_state <= StDone;
                  r_done  <= 1'b1;
               end
            end
            StDone: begin
               r_state <= StIdle;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

   // Next packing state: a push empties the pack, a capture lands in the next free slot
   always_comb begin
      w_pack_nxt     = w_push ? '0 : r_pack;
      w_pack_cnt_nxt = w_push ? '0 : r_pack_cnt;
      w_captured_nxt = r_captured;
      if (w_cap) begin
         for (int e = 0; e < int'(EPW); e++) begin
            if (e == int'(w_pack_cnt_nxt)) begin
               w_pack_nxt[e*GF_BIT +: GF_BIT] = i_dataB_tail;
            end
         end
         w_pack_cnt_nxt = w_pack_cnt_nxt + 1'b1;
         w_captured_nxt = r_captured + 1'b1;
      end
   end

   // Packing registers, cleared when a new readout starts
   always_ff @(posedge i_clk) begin
      if (i_rst || w_clear) begin
         r_pack     <= '0;
         r_pack_cnt <= '0;
         r_captured <= '0;
      end else begin
         r_pack     <= w_pack_nxt;
         r_pack_cnt <= w_pack_cnt_nxt;
         r_captured <= w_captured_nxt;
      end
   end

   // FIFO pointer wrap for non power-of-two depths
   always_comb begin
      w_wptr_nxt = (r_wptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wptr + 1'b1;
      w_rptr_nxt = (r_rptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rptr + 1'b1;
   end

   // Output FIFO; the credit rule guarantees a free entry whenever a push happens
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            r_fifo_mem[i] <= '0;
         end
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_fifo_cnt <= '0;
      end else begin
         if (w_push) begin
            r_fifo_mem[r_wptr] <= {w_push_last, r_pack};
            r_wptr             <= w_wptr_nxt;
         end
         if (w_pop) begin
            r_rptr <= w_rptr_nxt;
         end
         case ({w_push, w_pop})
            2'b10:   r_fifo_cnt <= r_fifo_cnt + 1'b1;
            2'b01:   r_fifo_cnt <= r_fifo_cnt - 1'b1;
            default: r_fifo_cnt <= r_fifo_cnt;
         endcase
      end
   end

   // Head injection: recirculate the tail when rotating, otherwise shift in zeros
   always_comb begin
`ifdef READOUT_ROTATE_EN
      o_dataB_head = w_is_shift ? i_dataB_tail : '0;
`else
      o_dataB_head = '0;
`endif
   end

   assign o_busy         = r_busy;
   assign o_done         = r_done;
   assign o_op_out       = r_op;
   assign o_gauss_op_out = 2'b00;
   assign o_start_out    = 1'b0;
   assign o_out_valid    = (r_fifo_cnt != '0);
   assign o_out_data     = o_out_valid ? r_fifo_mem[r_rptr][WORD_W-1:0] : '0;
   assign o_out_last     = o_out_valid ? r_fifo_mem[r_rptr][WORD_W] : 1'b0;

endmodule
